// File: rtl/host_cart_cfg_pkg.sv
// Purpose: shared types and register map for the cartridge-config PIO block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package host_cart_cfg_pkg;

  // Commit sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    APPLY = 2'd2
  } cfg_state_t;

  // Avalon word offsets; STAGE[i] at STAGE_BASE+i, ACTIVE[i] at STAGE_BASE+N_CH+i
  localparam int REG_CTRL       = 0;
  localparam int REG_STATUS     = 1;
  localparam int REG_STAGE_BASE = 2;

  // CTRL bits
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_IRQ_EN = 1;

  // STATUS bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

endpackage

// File: rtl/host_cart_cfg_sync2.sv
// Purpose: two-flop synchroniser for a single cart-side level signal.
// Latency: 2 clk cycles from input change to output change.
// Backpressure: none; level signal, sampled every cycle.
module host_cart_cfg_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Shift the asynchronous input through two flops; both reset to 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/host_cart_cfg_pio.sv
// Purpose: Avalon-MM staging/active config channels with idle-qualified atomic commit.
// Latency: out_port updates IDLE_QUAL+1 cycles after COMMIT when synced idle is already high.
// Backpressure: zero wait states; STAGE/COMMIT writes while busy are dropped.
// Optional: define HOST_CART_CFG_TIMEOUT_EN to abort a stuck WAIT after TIMEOUT cycles.
module host_cart_cfg_pio
  import host_cart_cfg_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          N_CH      = 2,
  parameter int          ADDR_W    = 4,
  parameter int          IDLE_QUAL = 4,
  parameter logic [31:0] RESET_VAL = 32'd0,
  parameter int          TIMEOUT   = 65535
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic                  cart_idle,
  output logic [N_CH*WIDTH-1:0] out_port,
  output logic                  apply_strobe,
  output logic                  irq
);

  localparam int               QW     = (IDLE_QUAL > 1) ? $clog2(IDLE_QUAL) : 1;
  localparam logic [WIDTH-1:0] RST_CH = RESET_VAL[WIDTH-1:0];

  cfg_state_t       state_q, state_d;
  logic             idle_s;
  logic             wr_en, wr_ctrl, wr_status, commit_req;
  logic             busy, qual_done, timeout_hit, apply_go, abort;
  logic [QW-1:0]    qual_q;
  logic             irq_en_q, done_q, err_q, irq_q;
  logic [WIDTH-1:0] stage_q  [N_CH];
  logic [WIDTH-1:0] active_q [N_CH];
  logic             unused_bits;

  host_cart_cfg_sync2 u_idle_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (cart_idle),
    .q       (idle_s)
  );

  assign wr_en      = chipselect & ~write_n;
  assign wr_ctrl    = wr_en && (address == ADDR_W'(REG_CTRL));
  assign wr_status  = wr_en && (address == ADDR_W'(REG_STATUS));
  assign commit_req = wr_ctrl && writedata[CTRL_COMMIT];
  assign qual_done  = idle_s && (qual_q == QW'(IDLE_QUAL - 1));

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; the ACTIVE copy fires on the WAIT->APPLY edge so out_port
  // and apply_strobe change together. Apply beats timeout if both are due.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    apply_go = 1'b0;
    abort    = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req) state_d = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (qual_done) begin
          state_d  = APPLY;
          apply_go = 1'b1;
        end else if (timeout_hit) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      APPLY: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign apply_strobe = (state_q == APPLY);
  assign irq          = irq_q;

  // Consecutive-idle qualifier: counts only in WAIT while synced idle is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                      qual_q <= '0;
    else if (state_q != WAIT || !idle_s || qual_done) qual_q <= '0;
    else                                               qual_q <= qual_q + QW'(1);
  end

`ifdef HOST_CART_CFG_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] wait_q;

  // WAIT dwell counter; zero outside WAIT so every commit starts it fresh
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              wait_q <= '0;
    else if (state_q == WAIT)  wait_q <= wait_q + TW'(1);
    else                       wait_q <= '0;
  end

  assign timeout_hit = (wait_q == TW'(TIMEOUT - 1));

  // Sticky error flag; a new abort wins over a same-cycle W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               err_q <= 1'b0;
    else if (abort)                             err_q <= 1'b1;
    else if (wr_status && writedata[STAT_ERR])  err_q <= 1'b0;
  end

  assign unused_bits = ^{writedata};
`else
  localparam logic [31:0] TIMEOUT_NC = 32'(TIMEOUT);

  assign timeout_hit = 1'b0;
  assign err_q       = 1'b0;
  assign unused_bits = ^{writedata, abort, TIMEOUT_NC};
`endif

  // Staging writes (blocked while busy) and atomic copy into the active set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        stage_q[i]  <= RST_CH;
        active_q[i] <= RST_CH;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr_en && !busy && (address == ADDR_W'(REG_STAGE_BASE + i)))
          stage_q[i] <= writedata[WIDTH-1:0];
        if (apply_go)
          active_q[i] <= stage_q[i];
      end
    end
  end

  // Control/status flags and the registered interrupt; DONE set wins over W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= writedata[CTRL_IRQ_EN];
      if (state_q == APPLY)                           done_q <= 1'b1;
      else if (wr_status && writedata[STAT_DONE])     done_q <= 1'b0;
      irq_q <= irq_en_q & (done_q | err_q);
    end
  end

  // Flatten active channels, ch0 in the LSBs
  always_comb begin
    out_port = '0;
    for (int i = 0; i < N_CH; i++) out_port[i*WIDTH +: WIDTH] = active_q[i];
  end

  // Zero-wait-state read mux; unmapped addresses read 0
  always_comb begin
    readdata = '0;
    if (address == ADDR_W'(REG_CTRL)) begin
      readdata[CTRL_IRQ_EN] = irq_en_q;
    end else if (address == ADDR_W'(REG_STATUS)) begin
      readdata[STAT_BUSY] = busy;
      readdata[STAT_DONE] = done_q;
      readdata[STAT_ERR]  = err_q;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (address == ADDR_W'(REG_STAGE_BASE + i))        readdata[WIDTH-1:0] = stage_q[i];
      if (address == ADDR_W'(REG_STAGE_BASE + N_CH + i)) readdata[WIDTH-1:0] = active_q[i];
    end
  end

endmodule

// File: tb/tb_host_cart_cfg_pio.sv
// Purpose: directed self-checking bench for host_cart_cfg_pio (WIDTH=8, N_CH=2, IDLE_QUAL=4, TIMEOUT=16).
// Latency: cycle-exact checks of commit-to-apply timing.
// Backpressure: n/a.
module tb_host_cart_cfg_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        cart_idle;
  logic [15:0] out_port;
  logic        apply_strobe;
  logic        irq;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  host_cart_cfg_pio #(
    .WIDTH     (8),
    .N_CH      (2),
    .ADDR_W    (4),
    .IDLE_QUAL (4),
    .RESET_VAL (32'd0),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .cart_idle    (cart_idle),
    .out_port     (out_port),
    .apply_strobe (apply_strobe),
    .irq          (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle Avalon write; returns 1ns into the following cycle
  task automatic avm_write(input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic avm_read(input logic [3:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 4'd0;
    writedata  = 32'd0;
    cart_idle  = 1'b0;
    repeat (3) tick();
    n_vec++; if (out_port !== 16'h0000) begin n_bad++; $display("FAIL reset_out_port: got %h want %h", out_port, 16'h0000); end
    avm_read(4'd1, rd);
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want %h", rd, 32'h0); end
    n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_vec++; if (apply_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", apply_strobe); end
    reset_n = 1'b1;
    tick();
    avm_read(4'd0, rd);
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_basic_commit();
    logic [31:0] rd;
    int first, strobes, strobe_at;
    avm_write(4'd2, 32'h2A);
    avm_write(4'd3, 32'h05);
    avm_write(4'd0, 32'h2);
    avm_write(4'd0, 32'h3);       // COMMIT in cycle 0
    cart_idle = 1'b1;             // raw idle rises in cycle 1
    first = -1; strobes = 0; strobe_at = -1;
    for (int n = 1; n <= 12; n++) begin
      if (apply_strobe === 1'b1) begin strobes++; if (strobe_at < 0) strobe_at = n; end
      if (first < 0 && out_port === 16'h052A) first = n;
      tick();
    end
    n_vec++; if (first !== 7) begin n_bad++; $display("FAIL basic_apply_cycle: got %0d want %0d", first, 7); end
    n_vec++; if (strobe_at !== 7) begin n_bad++; $display("FAIL basic_strobe_cycle: got %0d want %0d", strobe_at, 7); end
    n_vec++; if (strobes !== 1) begin n_bad++; $display("FAIL basic_strobe_len: got %0d want %0d", strobes, 1); end
    avm_read(4'd1, rd);
    n_vec++; if (rd !== 32'h2) begin n_bad++; $display("FAIL basic_status_done: got %h want %h", rd, 32'h2); end
    n_vec++; if (irq !== 1'b1) begin n_bad++; $display("FAIL basic_irq: got %b want 1", irq); end
    avm_read(4'd5, rd);
    n_vec++; if (rd !== 32'h05) begin n_bad++; $display("FAIL basic_active1: got %h want %h", rd, 32'h05); end
    avm_write(4'd1, 32'h2);
    tick();
    n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL basic_irq_clear: got %b want 0", irq); end
    avm_read(4'd1, rd);
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL basic_status_clear: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_idle_qual();
    logic [31:0] rd;
    int first, strobes;
    cart_idle = 1'b0;
    repeat (3) tick();
    avm_write(4'd2, 32'h11);
    avm_write(4'd3, 32'h22);
    avm_write(4'd0, 32'h3);
    avm_read(4'd1, rd);
    n_vec++; if (rd !== 32'h1) begin n_bad++; $display("FAIL qual_busy: got %h want %h", rd, 32'h1); end
    strobes = 0;
    cart_idle = 1'b1;             // IDLE_QUAL-1 cycles of idle only
    for (int n = 0; n < 3; n++) begin if (apply_strobe === 1'b1) strobes++; tick(); end
    cart_idle = 1'b0;
    for (int n = 0; n < 8; n++) begin if (apply_strobe === 1'b1) strobes++; tick(); end
    n_vec++; if (strobes !== 0) begin n_bad++; $display("FAIL qual_short_strobe: got %0d want %0d", strobes, 0); end
    n_vec++; if (out_port !== 16'h052A) begin n_bad++; $display("FAIL qual_short_out: got %h want %h", out_port, 16'h052A); end
    avm_read(4'd1, rd);
    n_vec++; if (rd !== 32'h1) begin n_bad++; $display("FAIL qual_still_busy: got %h want %h", rd, 32'h1); end
    cart_idle = 1'b1;
    first = -1;
    for (int n = 0; n <= 12; n++) begin
      if (apply_strobe === 1'b1) strobes++;
      if (first < 0 && out_port === 16'h2211) first = n;
      tick();
    end
    n_vec++; if (first !== 6) begin n_bad++; $display("FAIL qual_full_cycle: got %0d want %0d", first, 6); end
    n_vec++; if (strobes !== 1) begin n_bad++; $display("FAIL qual_full_strobe: got %0d want %0d", strobes, 1); end
    avm_write(4'd1, 32'h2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int first, strobes;
    cart_idle = 1'b0;
    repeat (3) tick();
    avm_write(4'd2, 32'h33);
    avm_write(4'd0, 32'h3);       // enter WAIT
    cart_idle = 1'b1;             // cycle 0
    tick();
    tick();
    avm_write(4'd2, 32'hFF);      // cycle 2, must be ignored
    avm_write(4'd0, 32'h1);       // cycle 3, COMMIT ignored, IRQ_EN cleared
    first = -1; strobes = 0;
    for (int n = 4; n <= 14; n++) begin
      if (apply_strobe === 1'b1) strobes++;
      if (first < 0 && out_port === 16'h2233) first = n;
      tick();
    end
    n_vec++; if (first !== 6) begin n_bad++; $display("FAIL busy_apply_cycle: got %0d want %0d", first, 6); end
    n_vec++; if (strobes !== 1) begin n_bad++; $display("FAIL busy_strobe: got %0d want %0d", strobes, 1); end
    avm_read(4'd2, rd);
    n_vec++; if (rd !== 32'h33) begin n_bad++; $display("FAIL busy_stage0: got %h want %h", rd, 32'h33); end
    avm_read(4'd0, rd);
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL busy_ctrl: got %h want %h", rd, 32'h0); end
    avm_read(4'd1, rd);
    n_vec++; if (rd !== 32'h2) begin n_bad++; $display("FAIL busy_status: got %h want %h", rd, 32'h2); end
    n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL busy_irq_masked: got %b want 0", irq); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    int strobes;
    cart_idle = 1'b0;
    repeat (3) tick();
    avm_write(4'd2, 32'h44);
    avm_write(4'd0, 32'h3);       // WAIT, IRQ_EN=1 with DONE still set
    tick();
    n_vec++; if (irq !== 1'b1) begin n_bad++; $display("FAIL rst_pre_irq: got %b want 1", irq); end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++; if (out_port !== 16'h0000) begin n_bad++; $display("FAIL rst_async_out: got %h want %h", out_port, 16'h0000); end
    n_vec++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_async_irq: got %b want 0", irq); end
    avm_read(4'd1, rd);
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_status: got %h want %h", rd, 32'h0); end
    avm_read(4'd2, rd);
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_stage0: got %h want %h", rd, 32'h0); end
    reset_n   = 1'b1;
    cart_idle = 1'b1;
    strobes = 0;
    for (int n = 0; n < 12; n++) begin if (apply_strobe === 1'b1) strobes++; tick(); end
    n_vec++; if (strobes !== 0) begin n_bad++; $display("FAIL rst_no_strobe: got %0d want %0d", strobes, 0); end
    n_vec++; if (out_port !== 16'h0000) begin n_bad++; $display("FAIL rst_out_hold: got %h want %h", out_port, 16'h0000); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    int strobes;
    cart_idle = 1'b0;
    repeat (3) tick();
    avm_write(4'd0, 32'h2);
    avm_write(4'd2, 32'h55);
    avm_write(4'd0, 32'h3);       // COMMIT; WAIT from cycle 1
    strobes = 0;
`ifdef HOST_CART_CFG_TIMEOUT_EN
    for (int n = 1; n < 16; n++) begin if (apply_strobe === 1'b1) strobes++; tick(); end
    avm_read(4'd1, rd);           // cycle 16: last WAIT cycle
    n_vec++; if (rd !== 32'h1) begin n_bad++; $display("FAIL to_last_wait: got %h want %h", rd, 32'h1); end
    tick();
    avm_read(4'd1, rd);           // cycle 17: aborted
    n_vec++; if (rd !== 32'h4) begin n_bad++; $display("FAIL to_status_err: got %h want %h", rd, 32'h4); end
    n_vec++; if (out_port !== 16'h0000) begin n_bad++; $display("FAIL to_out_hold: got %h want %h", out_port, 16'h0000); end
    n_vec++; if (strobes !== 0) begin n_bad++; $display("FAIL to_no_strobe: got %0d want %0d", strobes, 0); end
    tick();
    n_vec++; if (irq !== 1'b1) begin n_bad++; $display("FAIL to_irq: got %b want 1", irq); end
    avm_write(4'd1, 32'h4);
    avm_read(4'd1, rd);
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL to_err_w1c: got %h want %h", rd, 32'h0); end
    avm_read(4'd2, rd);
    n_vec++; if (rd !== 32'h55) begin n_bad++; $display("FAIL to_stage_kept: got %h want %h", rd, 32'h55); end
`else
    for (int n = 1; n <= 20; n++) begin if (apply_strobe === 1'b1) strobes++; tick(); end
    avm_read(4'd1, rd);
    n_vec++; if (rd !== 32'h1) begin n_bad++; $display("FAIL nto_still_busy: got %h want %h", rd, 32'h1); end
    n_vec++; if (strobes !== 0) begin n_bad++; $display("FAIL nto_no_strobe: got %0d want %0d", strobes, 0); end
    n_vec++; if (out_port !== 16'h0000) begin n_bad++; $display("FAIL nto_out_hold: got %h want %h", out_port, 16'h0000); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_idle_qual();
    test_back_to_back();
    test_reset_mid_wait();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
